// File: rtl/ap_mon_pkg.sv
// Shared types and constants for the ap_ctrl_hs transaction recorder.
package ap_mon_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_READY = 2'd1,
    STOPPED    = 2'd2
  } mon_state_t;

  localparam int REC_TS_W = 32;

  typedef struct packed {
    logic [REC_TS_W-1:0] start_ts;
    logic [REC_TS_W-1:0] latency;
    logic [REC_TS_W-1:0] interval;
  } txn_rec_t;

  localparam int              DROP_W   = 16;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

endpackage

// File: rtl/txn_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module txn_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the addresses match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ap_ctrl_txn_recorder.sv
// Passive ap_ctrl_hs monitor: timestamps starts, pairs them with completions and
// emits {start, latency, interval} records through an output FIFO.
module ap_ctrl_txn_recorder
  import ap_mon_pkg::*;
#(
  parameter int TS_W      = REC_TS_W,
  parameter int INFLIGHT  = 4,
  parameter int OUT_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  input  logic              ap_continue,
  input  logic              finish,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [TS_W-1:0]   rec_start_ts,
  output logic [TS_W-1:0]   rec_latency,
  output logic [TS_W-1:0]   rec_interval,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              start_ovf,
  output logic              orphan_done,
  output logic              drained
);
  localparam int REC_W = 3 * TS_W;

  mon_state_t       state, state_nxt;
  logic [TS_W-1:0]  ts, prev_s, sq_dout, new_lat, new_ivl;
  logic             have_prev;
  logic             start_ev, done_ev, sq_pop, sq_full, sq_empty;
  logic             of_pop, of_full, of_empty, drop_ev;
  logic [REC_W-1:0] of_din, of_dout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ts <= '0;
    else       ts <= ts + TS_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // finish wins over everything, so no start is recorded in the finish cycle.
  always_comb begin
    state_nxt = state;
    start_ev  = 1'b0;
    if (finish) begin
      state_nxt = STOPPED;
    end else begin
      case (state)
        IDLE: begin
          if (ap_start) begin
            start_ev  = 1'b1;
            state_nxt = ap_ready ? IDLE : WAIT_READY;
          end
        end
        WAIT_READY: if (ap_ready) state_nxt = IDLE;
        default:    state_nxt = STOPPED;
      endcase
    end
  end

  assign done_ev = ap_done & ap_continue;
  assign sq_pop  = done_ev & ~sq_empty;

  txn_fifo #(.W(TS_W), .DEPTH(INFLIGHT)) start_q (
    .clock (clock),
    .reset (reset),
    .push  (start_ev),
    .pop   (sq_pop),
    .din   (ts),
    .dout  (sq_dout),
    .full  (sq_full),
    .empty (sq_empty)
  );

  assign new_lat = ts - sq_dout;
  assign new_ivl = have_prev ? (sq_dout - prev_s) : '0;
  assign of_din  = {sq_dout, new_lat, new_ivl};

  assign rec_valid = ~of_empty;
  assign of_pop    = rec_valid & rec_ready;
  assign drop_ev   = sq_pop & of_full & ~of_pop;

  txn_fifo #(.W(REC_W), .DEPTH(OUT_DEPTH)) out_q (
    .clock (clock),
    .reset (reset),
    .push  (sq_pop),
    .pop   (of_pop),
    .din   (of_din),
    .dout  (of_dout),
    .full  (of_full),
    .empty (of_empty)
  );

  // prev_s follows every built record, including ones later dropped at the output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_s      <= '0;
      have_prev   <= 1'b0;
      drop_cnt    <= '0;
      start_ovf   <= 1'b0;
      orphan_done <= 1'b0;
    end else begin
      if (sq_pop) begin
        prev_s    <= sq_dout;
        have_prev <= 1'b1;
      end
      if (drop_ev && drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + DROP_W'(1);
      if (start_ev && sq_full && !sq_pop)  start_ovf <= 1'b1;
      if (done_ev && sq_empty)             orphan_done <= 1'b1;
    end
  end

  always_comb begin
    rec_start_ts = '0;
    rec_latency  = '0;
    rec_interval = '0;
    if (rec_valid) begin
      rec_start_ts = of_dout[REC_W-1 -: TS_W];
      rec_latency  = of_dout[2*TS_W-1 -: TS_W];
      rec_interval = of_dout[TS_W-1:0];
    end
  end

  assign drained = (state == STOPPED) && sq_empty && of_empty;

endmodule

// File: tb/tb_ap_ctrl_txn_recorder.sv
// Scoreboard bench for ap_ctrl_txn_recorder: expected records queued at completion, compared against consumed records.
module tb_ap_ctrl_txn_recorder;
  import ap_mon_pkg::*;

  localparam int TS_W = REC_TS_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b0;
  logic              finish = 1'b0, rec_ready = 1'b0;
  logic              rec_valid, start_ovf, orphan_done, drained;
  logic [TS_W-1:0]   rec_start_ts, rec_latency, rec_interval;
  logic [DROP_W-1:0] drop_cnt;

  int          total_cnt = 0;
  int          pass_cnt  = 0;
  int unsigned tb_ts     = 0;
  txn_rec_t    exp_q[$];
  txn_rec_t    obs_q[$];

  ap_ctrl_txn_recorder #(.TS_W(TS_W), .INFLIGHT(4), .OUT_DEPTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .ap_start     (ap_start),
    .ap_ready     (ap_ready),
    .ap_done      (ap_done),
    .ap_continue  (ap_continue),
    .finish       (finish),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .rec_start_ts (rec_start_ts),
    .rec_latency  (rec_latency),
    .rec_interval (rec_interval),
    .drop_cnt     (drop_cnt),
    .start_ovf    (start_ovf),
    .orphan_done  (orphan_done),
    .drained      (drained)
  );

  always #5 clock = ~clock;

  // Reference cycle counter: the timestamp the recorder should be showing.
  always @(posedge clock or posedge reset) begin
    if (reset) tb_ts <= 0;
    else       tb_ts <= tb_ts + 1;
  end

  always @(negedge clock) begin
    if (!reset && rec_valid && rec_ready) obs_q.push_back('{rec_start_ts, rec_latency, rec_interval});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic txn_rec_t mk(input int unsigned s, input int unsigned l, input int unsigned i);
    mk = '{start_ts: s, latency: l, interval: i};
  endfunction

  task automatic wait_ts(input int unsigned n);
    int guard = 0;
    while (tb_ts != n && guard < 1000) begin
      @(posedge clock); #1;
      guard++;
    end
    if (tb_ts != n) begin
      total_cnt++;
      $display("FAIL wait_ts: ts=%0d required %0d", tb_ts, n);
    end
  endtask

  task automatic do_reset();
    {ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready} = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    {ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready} = '0;
    reset = 1'b1;
    @(posedge clock); #1;
    total_cnt++; if (rec_valid !== 1'b0) $display("FAIL rst_valid: rec_valid=%b required 0", rec_valid); else pass_cnt++;
    total_cnt++; if ({rec_start_ts, rec_latency, rec_interval} !== '0) $display("FAIL rst_fields: got %0d/%0d/%0d required 0/0/0", rec_start_ts, rec_latency, rec_interval); else pass_cnt++;
    total_cnt++; if (drained !== 1'b0) $display("FAIL rst_drained: drained=%b required 0", drained); else pass_cnt++;
    @(posedge clock); #1;
    reset = 1'b0;
    wait_ts(2);
    total_cnt++; if (drop_cnt !== 16'd0) $display("FAIL rst_drop: drop_cnt=%0d required 0", drop_cnt); else pass_cnt++;
    total_cnt++; if ({start_ovf, orphan_done} !== 2'b00) $display("FAIL rst_flags: ovf/orphan=%b%b required 00", start_ovf, orphan_done); else pass_cnt++;
    total_cnt++; if ({rec_valid, drained} !== 2'b00) $display("FAIL rst_idle: valid/drained=%b%b required 00", rec_valid, drained); else pass_cnt++;
  endtask

  task automatic test_single();
    txn_rec_t o, e;
    do_reset();
    rec_ready = 1'b1;
    wait_ts(10); ap_start = 1'b1; ap_ready = 1'b1;
    wait_ts(11); ap_start = 1'b0; ap_ready = 1'b0;
    wait_ts(25); ap_done = 1'b1; ap_continue = 1'b1;
    exp_q.push_back(mk(10, 15, 0));
    total_cnt++; if (rec_valid !== 1'b0) $display("FAIL single_early: rec_valid=%b at ts 25 required 0", rec_valid); else pass_cnt++;
    wait_ts(26); ap_done = 1'b0; ap_continue = 1'b0;
    total_cnt++; if (rec_valid !== 1'b1) $display("FAIL single_latency: rec_valid=%b at ts 26 required 1", rec_valid); else pass_cnt++;
    wait_ts(29);
    total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL single_count: got %0d records required %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total_cnt++;
      if (o !== e) $display("FAIL single_rec: got %0d/%0d/%0d required %0d/%0d/%0d", o.start_ts, o.latency, o.interval, e.start_ts, e.latency, e.interval); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    txn_rec_t o, e;
    do_reset();
    rec_ready = 1'b1;
    wait_ts(5);  ap_start = 1'b1; ap_ready = 1'b1;
    wait_ts(6);  ap_start = 1'b0; ap_ready = 1'b0;
    wait_ts(9);  ap_start = 1'b1; ap_ready = 1'b1;
    wait_ts(10); ap_start = 1'b0; ap_ready = 1'b0;
    wait_ts(20); ap_done = 1'b1; ap_continue = 1'b1; exp_q.push_back(mk(5, 15, 0));
    wait_ts(21); ap_done = 1'b0; ap_continue = 1'b0;
    wait_ts(24); ap_done = 1'b1; ap_continue = 1'b1; exp_q.push_back(mk(9, 15, 4));
    wait_ts(25); ap_done = 1'b0; ap_continue = 1'b0;
    wait_ts(28);
    total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL b2b_count: got %0d records required %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total_cnt++;
      if (o !== e) $display("FAIL b2b_rec: got %0d/%0d/%0d required %0d/%0d/%0d", o.start_ts, o.latency, o.interval, e.start_ts, e.latency, e.interval); else pass_cnt++;
    end
  endtask

  task automatic test_start_ovf();
    txn_rec_t o, e;
    do_reset();
    rec_ready = 1'b1;
    wait_ts(2); ap_start = 1'b1; ap_ready = 1'b1;
    wait_ts(6);
    total_cnt++; if (start_ovf !== 1'b0) $display("FAIL ovf_early: start_ovf=%b after 4 starts required 0", start_ovf); else pass_cnt++;
    wait_ts(7); ap_start = 1'b0; ap_ready = 1'b0;
    total_cnt++; if (start_ovf !== 1'b1) $display("FAIL ovf_set: start_ovf=%b after 5 starts required 1", start_ovf); else pass_cnt++;
    wait_ts(10); ap_done = 1'b1; ap_continue = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(2 + k, 8, (k == 0) ? 0 : 1));
    wait_ts(14); ap_done = 1'b0; ap_continue = 1'b0;
    wait_ts(17);
    total_cnt++; if ({start_ovf, orphan_done} !== 2'b10) $display("FAIL ovf_flags: ovf/orphan=%b%b required 10", start_ovf, orphan_done); else pass_cnt++;
    total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL ovf_count: got %0d records required %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total_cnt++;
      if (o !== e) $display("FAIL ovf_rec: got %0d/%0d/%0d required %0d/%0d/%0d", o.start_ts, o.latency, o.interval, e.start_ts, e.latency, e.interval); else pass_cnt++;
    end
  endtask

  task automatic test_drop();
    txn_rec_t o, e;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      wait_ts(2 + 2 * k); ap_done = 1'b0; ap_continue = 1'b0; ap_start = 1'b1; ap_ready = 1'b1;
      wait_ts(3 + 2 * k); ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b1; ap_continue = 1'b1;
      if (k < 8) exp_q.push_back(mk(2 + 2 * k, 1, (k == 0) ? 0 : 2));
    end
    wait_ts(22); ap_done = 1'b0; ap_continue = 1'b0;
    total_cnt++; if (drop_cnt !== 16'd2) $display("FAIL drop_cnt: drop_cnt=%0d required 2", drop_cnt); else pass_cnt++;
    total_cnt++; if ({rec_valid, orphan_done} !== 2'b10) $display("FAIL drop_state: valid/orphan=%b%b required 10", rec_valid, orphan_done); else pass_cnt++;
    wait_ts(25);
    total_cnt++; if ({rec_start_ts, rec_latency, rec_interval} !== {32'd2, 32'd1, 32'd0}) $display("FAIL drop_hold: got %0d/%0d/%0d required 2/1/0", rec_start_ts, rec_latency, rec_interval); else pass_cnt++;
    rec_ready = 1'b1;
    wait_ts(36);
    total_cnt++; if ({rec_valid, drop_cnt} !== {1'b0, 16'd2}) $display("FAIL drop_after: valid=%b drop_cnt=%0d required 0 and 2", rec_valid, drop_cnt); else pass_cnt++;
    total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL drop_count: got %0d records required %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total_cnt++;
      if (o !== e) $display("FAIL drop_rec: got %0d/%0d/%0d required %0d/%0d/%0d", o.start_ts, o.latency, o.interval, e.start_ts, e.latency, e.interval); else pass_cnt++;
    end
  endtask

  task automatic test_orphan();
    do_reset();
    rec_ready = 1'b1;
    wait_ts(1); ap_done = 1'b1; ap_continue = 1'b0;
    wait_ts(2); ap_done = 1'b0;
    total_cnt++; if (orphan_done !== 1'b0) $display("FAIL orphan_nocont: orphan_done=%b required 0", orphan_done); else pass_cnt++;
    wait_ts(3); ap_done = 1'b1; ap_continue = 1'b1;
    wait_ts(4); ap_done = 1'b0; ap_continue = 1'b0;
    total_cnt++; if (orphan_done !== 1'b1) $display("FAIL orphan_set: orphan_done=%b required 1", orphan_done); else pass_cnt++;
    wait_ts(6);
    total_cnt++; if ({rec_valid, start_ovf} !== 2'b00) $display("FAIL orphan_norec: valid/ovf=%b%b required 00", rec_valid, start_ovf); else pass_cnt++;
    total_cnt++; if (obs_q.size() != 0) $display("FAIL orphan_count: got %0d records required 0", obs_q.size()); else pass_cnt++;
  endtask

  task automatic test_finish();
    txn_rec_t o, e;
    do_reset();
    wait_ts(2);  ap_start = 1'b1; ap_ready = 1'b1;
    wait_ts(3);  ap_start = 1'b0; ap_ready = 1'b0;
    wait_ts(4);  finish = 1'b1;
    wait_ts(5);  finish = 1'b0;
    total_cnt++; if (drained !== 1'b0) $display("FAIL fin_pending: drained=%b with start pending required 0", drained); else pass_cnt++;
    wait_ts(8);  ap_start = 1'b1; ap_ready = 1'b1;
    wait_ts(9);  ap_start = 1'b0; ap_ready = 1'b0;
    wait_ts(12); ap_done = 1'b1; ap_continue = 1'b1; exp_q.push_back(mk(2, 10, 0));
    wait_ts(13); ap_done = 1'b0; ap_continue = 1'b0;
    total_cnt++; if ({rec_valid, drained} !== 2'b10) $display("FAIL fin_held: valid/drained=%b%b required 10", rec_valid, drained); else pass_cnt++;
    rec_ready = 1'b1;
    wait_ts(14);
    total_cnt++; if ({rec_valid, drained} !== 2'b01) $display("FAIL fin_drained: valid/drained=%b%b required 01", rec_valid, drained); else pass_cnt++;
    wait_ts(15); ap_done = 1'b1; ap_continue = 1'b1;
    wait_ts(16); ap_done = 1'b0; ap_continue = 1'b0;
    total_cnt++; if ({orphan_done, rec_valid, drained} !== 3'b101) $display("FAIL fin_ignored: orphan/valid/drained=%b%b%b required 101", orphan_done, rec_valid, drained); else pass_cnt++;
    total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL fin_count: got %0d records required %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total_cnt++;
      if (o !== e) $display("FAIL fin_rec: got %0d/%0d/%0d required %0d/%0d/%0d", o.start_ts, o.latency, o.interval, e.start_ts, e.latency, e.interval); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wait_ts(2); ap_start = 1'b1; ap_ready = 1'b1;
    wait_ts(3); ap_start = 1'b0; ap_ready = 1'b0;
    wait_ts(4); ap_done = 1'b1; ap_continue = 1'b1; exp_q.push_back(mk(2, 2, 0));
    wait_ts(5); ap_done = 1'b0; ap_continue = 1'b0; ap_start = 1'b1; ap_ready = 1'b1;
    wait_ts(6); ap_start = 1'b0; ap_ready = 1'b0;
    total_cnt++; if (rec_valid !== 1'b1) $display("FAIL mid_pre: rec_valid=%b before reset required 1", rec_valid); else pass_cnt++;
    wait_ts(7);
    reset = 1'b1;
    #1;
    total_cnt++; if ({rec_valid, drained, rec_start_ts} !== {2'b00, 32'd0}) $display("FAIL mid_async: valid=%b drained=%b start=%0d required 0/0/0", rec_valid, drained, rec_start_ts); else pass_cnt++;
    exp_q.delete();
    obs_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    rec_ready = 1'b1;
    wait_ts(3); ap_done = 1'b1; ap_continue = 1'b1;
    wait_ts(4); ap_done = 1'b0; ap_continue = 1'b0;
    total_cnt++; if ({orphan_done, rec_valid} !== 2'b10) $display("FAIL mid_cleared: orphan/valid=%b%b required 10", orphan_done, rec_valid); else pass_cnt++;
    wait_ts(6);
    total_cnt++; if ({drop_cnt, start_ovf} !== 17'd0 || obs_q.size() != 0) $display("FAIL mid_after: drop_cnt=%0d ovf=%b records=%0d required 0/0/0", drop_cnt, start_ovf, obs_q.size()); else pass_cnt++;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_start_ovf();
    test_drop();
    test_orphan();
    test_finish();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
